gf_log_rom_arbiter: RTL and testbench

- Shares one single-port GF(2^8) log ROM (decimal-to-power lookup) between NUM_REQ decoder stages, e.g. Berlekamp-Massey, Chien/Forney and error-magnitude units.
- Round-robin arbitration with a valid/ready request handshake.
- Drives the ROM's re/address, registers the ROM output and routes each result back to its requester.
- Response latency is fixed; responses are never back-pressured.

---
 rtl/gf_arb_pkg.sv | 35 +++
 rtl/gf_log_rom_arbiter_if.sv | 27 ++
 rtl/gf_rr_arbiter.sv | 23 ++
 rtl/gf_log_rom_arbiter.sv | 93 +++++++++
 tb/tb_gf_log_rom_arbiter.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/gf_arb_pkg.sv
// rtl/gf_arb_pkg.sv - shared widths, log(0) sentinel and round-robin winner search
package gf_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int MAX_REQ    = 8;
    localparam int RR_IDX_W   = 3;
    localparam logic [7:0] LOG_ZERO_SENTINEL = 8'hFF;

    // Scan upward from ptr+1 (wrapping at num_req); returns ptr when nothing is valid.
    function automatic logic [RR_IDX_W-1:0] rr_next(
        input logic [RR_IDX_W-1:0] ptr,
        input logic [MAX_REQ-1:0]  valid_vec,
        input int                  num_req
    );
        logic [RR_IDX_W-1:0] idx;
        logic [RR_IDX_W-1:0] win;
        logic                found;
        idx   = ptr;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < num_req) begin
                if (idx == RR_IDX_W'(num_req - 1)) idx = '0;
                else                               idx = idx + 1'b1;
                if (!found && valid_vec[idx]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/gf_log_rom_arbiter_if.sv
// rtl/gf_log_rom_arbiter_if.sv - request, ROM and response signals of the log-ROM arbiter
interface gf_log_rom_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      flush;
    logic                      rom_re;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_data;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_data;
    logic                      resp_zero;

    modport slave (
        input  req_valid, req_addr, flush, rom_data,
        output req_ready, rom_re, rom_addr, resp_valid, resp_data, resp_zero
    );

    modport master (
        output req_valid, req_addr, flush, rom_data,
        input  req_ready, rom_re, rom_addr, resp_valid, resp_data, resp_zero
    );
endinterface

// File: rtl/gf_rr_arbiter.sv
// rtl/gf_rr_arbiter.sv - combinational round-robin picker: request vector + pointer -> one-hot grant
module gf_rr_arbiter
    import gf_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   winner_o
);
    logic [RR_IDX_W-1:0] pick;

    always_comb begin
        pick     = rr_next(RR_IDX_W'(ptr_i), MAX_REQ'(req_i), NUM_REQ);
        winner_o = PTR_W'(pick);
        grant_o  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_o[i] = (|req_i) && (winner_o == PTR_W'(i));
        end
    end
endmodule

// File: rtl/gf_log_rom_arbiter.sv
// rtl/gf_log_rom_arbiter.sv - shares one log ROM among NUM_REQ requesters; GF_LOG_ZERO_FLAG_EN adds resp_zero
module gf_log_rom_arbiter
    import gf_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input logic                 clk,
    input logic                 reset,
    gf_log_rom_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d, winner;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] s1_onehot_q, s1_onehot_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic               s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  resp_data_q, resp_data_d;
    logic               accept, deliver;

    gf_rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .req_i    (bus.req_valid),
        .ptr_i    (rr_ptr_q),
        .grant_o  (grant),
        .winner_o (winner)
    );

    // Flush blocks new grants and kills whatever sits in stage 1.
    always_comb begin
        accept  = (|grant) && !bus.flush;
        deliver = s1_valid_q && !bus.flush;
        addr_d  = addr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && grant[i]) addr_d = bus.req_addr[i*ADDR_W +: ADDR_W];
        end
        rr_ptr_d     = accept ? winner : rr_ptr_q;
        s1_valid_d   = accept;
        s1_onehot_d  = accept ? grant : '0;
        resp_valid_d = deliver ? s1_onehot_q : '0;
        resp_data_d  = deliver ? bus.rom_data : resp_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q     <= PTR_W'(NUM_REQ - 1);
            addr_q       <= '0;
            s1_valid_q   <= 1'b0;
            s1_onehot_q  <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            addr_q       <= addr_d;
            s1_valid_q   <= s1_valid_d;
            s1_onehot_q  <= s1_onehot_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign bus.req_ready  = bus.flush ? '0 : grant;
    assign bus.rom_re     = accept;
    assign bus.rom_addr   = addr_d;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;

`ifdef GF_LOG_ZERO_FLAG_EN
    logic s1_zero_q, s1_zero_d;
    logic resp_zero_q, resp_zero_d;

    always_comb begin
        s1_zero_d   = accept && (addr_d == '0);
        resp_zero_d = deliver && s1_zero_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_zero_q   <= 1'b0;
            resp_zero_q <= 1'b0;
        end else begin
            s1_zero_q   <= s1_zero_d;
            resp_zero_q <= resp_zero_d;
        end
    end

    assign bus.resp_zero = resp_zero_q;
`else
    assign bus.resp_zero = 1'b0;
`endif
endmodule

// File: tb/tb_gf_log_rom_arbiter.sv
// tb/tb_gf_log_rom_arbiter.sv - scoreboard bench for gf_log_rom_arbiter with a GF(2^8) log ROM model
module tb_gf_log_rom_arbiter;
    import gf_arb_pkg::*;

`ifdef GF_LOG_ZERO_FLAG_EN
    localparam logic ZF = 1'b1;
`else
    localparam logic ZF = 1'b0;
`endif

    typedef struct {
        logic [3:0] onehot;
        logic [7:0] data;
        logic       zero;
        int         due;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    logic [7:0] log_tbl [256];

    gf_log_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8)) bus ();

    gf_log_rom_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log table for primitive polynomial x^8+x^4+x^3+x^2+1.
    initial begin : build_rom
        logic [7:0] x;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            log_tbl[x] = i[7:0];
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        log_tbl[0] = LOG_ZERO_SENTINEL;
    end

    always @(posedge clk) if (bus.rom_re) bus.rom_data <= log_tbl[bus.rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (bus.resp_valid != 4'b0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(bus.resp_valid), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_onehot", 32'(bus.resp_valid), 32'(e.onehot));
                    chk("resp_data", 32'(bus.resp_data), 32'(e.data));
                    chk("resp_zero", 32'(bus.resp_zero), 32'(e.zero));
                    chk("resp_cycle", 32'(cyc), 32'(e.due));
                end
            end else begin
                chk("zero_idle", 32'(bus.resp_zero), 32'h0);
            end
        end
    end

    // Called at posedge+1; checks the combinational grant at the negedge.
    task automatic step(input string name, input logic [3:0] v, input logic [31:0] a,
                        input logic [3:0] exp_ready, input logic [7:0] exp_addr,
                        input logic [7:0] exp_data, input logic exp_zero);
        bus.req_valid = v;
        bus.req_addr  = a;
        @(negedge clk);
        chk({name, "_ready"}, 32'(bus.req_ready), 32'(exp_ready));
        chk({name, "_re"}, 32'(bus.rom_re), 32'(|exp_ready));
        if (exp_ready != 4'b0) begin
            chk({name, "_addr"}, 32'(bus.rom_addr), 32'(exp_addr));
            sb.push_back('{onehot: exp_ready, data: exp_data, zero: exp_zero, due: cyc + 2});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc           = 0;
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b0;
        bus.flush     = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_addr  = 32'h10FF0802;
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_resp_data", 32'(bus.resp_data), 32'h0);
        chk("rst_resp_zero", 32'(bus.resp_zero), 32'h0);
        chk("rst_ready", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 4'h0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin: grants 0,1,2,3 repeating
        for (int r = 0; r < 2; r++) begin
            step("rr0", 4'hF, 32'h10FF0802, 4'b0001, 8'h02, 8'h01, 1'b0);
            step("rr1", 4'hF, 32'h10FF0802, 4'b0010, 8'h08, 8'h03, 1'b0);
            step("rr2", 4'hF, 32'h10FF0802, 4'b0100, 8'hFF, 8'hAF, 1'b0);
            step("rr3", 4'hF, 32'h10FF0802, 4'b1000, 8'h10, 8'h04, 1'b0);
        end
        step("idle", 4'h0, 32'h0, 4'b0, 8'h0, 8'h0, 1'b0);

        step("single", 4'b0001, 32'h00000003, 4'b0001, 8'h03, 8'h19, 1'b0);
        step("idle", 4'h0, 32'h0, 4'b0, 8'h0, 8'h0, 1'b0);

        step("b2b0", 4'b0100, 32'h00020000, 4'b0100, 8'h02, 8'h01, 1'b0);
        step("b2b1", 4'b0100, 32'h00030000, 4'b0100, 8'h03, 8'h19, 1'b0);
        step("b2b2", 4'b0100, 32'h00080000, 4'b0100, 8'h08, 8'h03, 1'b0);
        repeat (2) step("idle", 4'h0, 32'h0, 4'b0, 8'h0, 8'h0, 1'b0);

        // Flush: the accepted lookup is dropped, so its expectation is withdrawn
        step("flush_acc", 4'b0001, 32'h00000003, 4'b0001, 8'h03, 8'h19, 1'b0);
        void'(sb.pop_back());
        bus.flush = 1'b1;
        step("flush_blk", 4'b0010, 32'h00000300, 4'b0, 8'h0, 8'h0, 1'b0);
        bus.flush = 1'b0;
        step("flush_rec", 4'b0010, 32'h00000300, 4'b0010, 8'h03, 8'h19, 1'b0);
        repeat (3) step("idle", 4'h0, 32'h0, 4'b0, 8'h0, 8'h0, 1'b0);

        // Async reset while a lookup sits in stage 1
        step("rst_acc", 4'b0001, 32'h00000008, 4'b0001, 8'h08, 8'h03, 1'b0);
        bus.req_valid = 4'h0;
        chk("pre_rst_data", 32'(bus.resp_data), 32'h19);
        #2;
        sb.delete();
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.resp_valid), 32'h0);
        chk("mid_rst_data", 32'(bus.resp_data), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step("rst_rr", 4'hF, 32'h10FF0802, 4'b0001, 8'h02, 8'h01, 1'b0);
        step("idle", 4'h0, 32'h0, 4'b0, 8'h0, 8'h0, 1'b0);

        step("zero0", 4'b0001, 32'h00000000, 4'b0001, 8'h00, 8'hFF, ZF);
        step("zero1", 4'b0001, 32'h00000001, 4'b0001, 8'h01, 8'h00, 1'b0);
        bus.req_valid = 4'h0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
